// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the fetch-stage branch predictor.
//   branch_kind_e : 2-bit kind of a control-transfer instruction
//                   (COND=00, JUMP=01, CALL=10, RET=11).
//   ctr_sat_inc   : saturating increment of a counter of a given width.
//   ctr_sat_dec   : saturating decrement (floors at zero).
// The counter helpers work on a 32-bit carrier so that a module can call them
// with its own COUNTER_BITS localparam and truncate the result.
// -----------------------------------------------------------------------------
package bp_pkg;

    typedef enum logic [1:0] {
        KIND_COND = 2'b00,
        KIND_JUMP = 2'b01,
        KIND_CALL = 2'b10,
        KIND_RET  = 2'b11
    } branch_kind_e;

    // Largest value a counter of 'width' bits can hold.
    function automatic logic [31:0] ctr_max(input int unsigned width);
        logic [31:0] max_val;
        if (width >= 32) begin
            max_val = '1;
        end else begin
            max_val = (32'd1 << width) - 32'd1;
        end
        return max_val;
    endfunction

    function automatic logic [31:0] ctr_sat_inc(input logic [31:0] value,
                                                input int unsigned width);
        logic [31:0] result;
        if (value >= ctr_max(width)) begin
            result = ctr_max(width);
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

    function automatic logic [31:0] ctr_sat_dec(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'd0) begin
            result = 32'd0;
        end else begin
            result = value - 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/btb_ras_predictor_if.sv
// -----------------------------------------------------------------------------
// btb_ras_predictor_if
// Bundles the fetch-side lookup and the execute-side training signals of the
// branch predictor.
//   master : fetch/execute side (drives pc_f, fetch_fire_f, upd_*, flush_e,
//            receives pred_*)
//   slave  : the predictor (receives lookups/updates, drives pred_*)
// Signals:
//   pc_f, fetch_fire_f                     fetch PC and "accepted" strobe
//   pred_hit_f, pred_taken_f, pred_target_f combinational prediction
//   upd_valid_e, upd_pc_e, upd_target_e,
//   upd_taken_e, upd_kind_e                resolved branch from execute
//   flush_e                                mispredict flush
// -----------------------------------------------------------------------------
interface btb_ras_predictor_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] pc_f;
    logic                  fetch_fire_f;
    logic                  pred_hit_f;
    logic                  pred_taken_f;
    logic [DATA_WIDTH-1:0] pred_target_f;
    logic                  upd_valid_e;
    logic [DATA_WIDTH-1:0] upd_pc_e;
    logic [DATA_WIDTH-1:0] upd_target_e;
    logic                  upd_taken_e;
    logic [1:0]            upd_kind_e;
    logic                  flush_e;

    modport master (
        output pc_f, fetch_fire_f,
        output upd_valid_e, upd_pc_e, upd_target_e, upd_taken_e, upd_kind_e,
        output flush_e,
        input  pred_hit_f, pred_taken_f, pred_target_f
    );

    modport slave (
        input  pc_f, fetch_fire_f,
        input  upd_valid_e, upd_pc_e, upd_target_e, upd_taken_e, upd_kind_e,
        input  flush_e,
        output pred_hit_f, pred_taken_f, pred_target_f
    );

endinterface

// File: rtl/ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Speculative return address stack built on a circular buffer.
//   clk, rst   : clock, asynchronous active-low reset
//   push       : write push_data on top (overwrites the oldest entry when full)
//   pop        : drop the top entry (ignored when empty)
//   push_data  : return address to push
//   flush      : discard all entries; wins over a same-cycle push or pop
//   top        : current top-of-stack value (meaningful only when !empty)
//   empty/full : occupancy flags
// -----------------------------------------------------------------------------
module ras_stack #(
    parameter int DATA_WIDTH = 32,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] top,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_BITS = $clog2(RAS_DEPTH);
    localparam logic [PTR_BITS:0] COUNT_FULL = (PTR_BITS + 1)'(RAS_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RAS_DEPTH];
    // ptr names the slot the next push writes; the top lives one below it.
    logic [PTR_BITS-1:0]   ptr;
    logic [PTR_BITS:0]     count;

    // A push on a full stack still advances ptr, so the slot it overwrites is
    // the oldest surviving entry and count simply stays saturated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr + PTR_BITS'(1);
            if (count != COUNT_FULL) begin
                count <= count + (PTR_BITS + 1)'(1);
            end
        end else if (pop && (count != '0)) begin
            ptr   <= ptr - PTR_BITS'(1);
            count <= count - (PTR_BITS + 1)'(1);
        end
    end

    assign top   = mem[ptr - PTR_BITS'(1)];
    assign empty = (count == '0);
    assign full  = (count == COUNT_FULL);

endmodule

// File: rtl/btb_ras_predictor.sv
// -----------------------------------------------------------------------------
// btb_ras_predictor
// Fetch-stage branch predictor: direct-mapped BTB with saturating counters and
// a speculative return address stack.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : btb_ras_predictor_if.slave
//              lookup  : pc_f / fetch_fire_f in, pred_hit_f / pred_taken_f /
//                        pred_target_f out (combinational, 0-cycle latency)
//              training: upd_valid_e, upd_pc_e, upd_target_e, upd_taken_e,
//                        upd_kind_e (registered, visible the next cycle)
//              flush_e : empties the RAS at the next edge
// -----------------------------------------------------------------------------
module btb_ras_predictor
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BTB_ROWS     = 16,
    parameter int COUNTER_BITS = 2,
    parameter int RAS_DEPTH    = 4
) (
    input logic                 clk,
    input logic                 rst,
    btb_ras_predictor_if.slave  bus
);

    localparam int INDEX_BITS = $clog2(BTB_ROWS);
    localparam int TAG_BITS   = DATA_WIDTH - INDEX_BITS - 2;
    // Weak-taken: only the counter MSB set.
    localparam logic [COUNTER_BITS-1:0] CTR_WEAK = COUNTER_BITS'(1) << (COUNTER_BITS - 1);

    logic                    btb_valid  [BTB_ROWS];
    logic [TAG_BITS-1:0]     btb_tag    [BTB_ROWS];
    logic [DATA_WIDTH-1:0]   btb_target [BTB_ROWS];
    logic [COUNTER_BITS-1:0] btb_ctr    [BTB_ROWS];
    branch_kind_e            btb_kind   [BTB_ROWS];

    logic [INDEX_BITS-1:0]   idx_f;
    logic [TAG_BITS-1:0]     tag_f;
    logic                    hit_f;
    branch_kind_e            kind_f;
    logic [DATA_WIDTH-1:0]   pc_plus4_f;

    logic [INDEX_BITS-1:0]   idx_e;
    logic [TAG_BITS-1:0]     tag_e;
    logic                    hit_e;
    branch_kind_e            kind_e;
    logic [COUNTER_BITS-1:0] ctr_inc_e;
    logic [COUNTER_BITS-1:0] ctr_dec_e;

    logic                    ras_push;
    logic                    ras_pop;
    logic [DATA_WIDTH-1:0]   ras_top;
    logic                    ras_empty;
    logic                    ras_full;

    assign idx_f      = bus.pc_f[INDEX_BITS+1:2];
    assign tag_f      = bus.pc_f[DATA_WIDTH-1:INDEX_BITS+2];
    assign hit_f      = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);
    assign kind_f     = btb_kind[idx_f];
    assign pc_plus4_f = bus.pc_f + DATA_WIDTH'(4);

    always_comb begin
        bus.pred_hit_f    = 1'b0;
        bus.pred_taken_f  = 1'b0;
        bus.pred_target_f = pc_plus4_f;
        if (hit_f) begin
            bus.pred_hit_f = 1'b1;
            case (kind_f)
                KIND_COND: begin
                    bus.pred_taken_f = btb_ctr[idx_f][COUNTER_BITS-1];
                    if (btb_ctr[idx_f][COUNTER_BITS-1]) begin
                        bus.pred_target_f = btb_target[idx_f];
                    end
                end
                KIND_RET: begin
                    // An empty RAS falls back to the target last seen for this RET.
                    bus.pred_taken_f  = 1'b1;
                    bus.pred_target_f = ras_empty ? btb_target[idx_f] : ras_top;
                end
                default: begin
                    bus.pred_taken_f  = 1'b1;
                    bus.pred_target_f = btb_target[idx_f];
                end
            endcase
        end
    end

    // The RAS only moves for fetches that actually leave the fetch stage.
    assign ras_push = bus.fetch_fire_f && hit_f && (kind_f == KIND_CALL);
    assign ras_pop  = bus.fetch_fire_f && hit_f && (kind_f == KIND_RET) && !ras_empty;

    ras_stack #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4_f),
        .flush     (bus.flush_e),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign idx_e     = bus.upd_pc_e[INDEX_BITS+1:2];
    assign tag_e     = bus.upd_pc_e[DATA_WIDTH-1:INDEX_BITS+2];
    assign hit_e     = btb_valid[idx_e] && (btb_tag[idx_e] == tag_e);
    assign kind_e    = branch_kind_e'(bus.upd_kind_e);
    assign ctr_inc_e = COUNTER_BITS'(ctr_sat_inc(32'(btb_ctr[idx_e]), COUNTER_BITS));
    assign ctr_dec_e = COUNTER_BITS'(ctr_sat_dec(32'(btb_ctr[idx_e])));

    // Training writes land at the edge, so a lookup of the same index in the
    // same cycle still sees the old entry. A not-taken COND that misses is
    // not worth a BTB slot and leaves the table untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BTB_ROWS; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= CTR_WEAK;
                btb_kind[i]   <= KIND_COND;
            end
        end else if (bus.upd_valid_e) begin
            if (hit_e) begin
                if (kind_e == KIND_COND) begin
                    btb_ctr[idx_e] <= bus.upd_taken_e ? ctr_inc_e : ctr_dec_e;
                end
                if (bus.upd_taken_e) begin
                    btb_target[idx_e] <= bus.upd_target_e;
                end
                btb_kind[idx_e] <= kind_e;
            end else if (bus.upd_taken_e || (kind_e != KIND_COND)) begin
                btb_valid[idx_e]  <= 1'b1;
                btb_tag[idx_e]    <= tag_e;
                btb_target[idx_e] <= bus.upd_target_e;
                btb_ctr[idx_e]    <= CTR_WEAK;
                btb_kind[idx_e]   <= kind_e;
            end
        end
    end

endmodule

// File: tb/tb_btb_ras_predictor.sv
// -----------------------------------------------------------------------------
// tb_btb_ras_predictor
// Bench for btb_ras_predictor: directed sequence with hand-computed
// expectations, then randomized traffic compared every cycle against a
// table-and-queue model of the predictor.
// -----------------------------------------------------------------------------
module tb_btb_ras_predictor;
    import bp_pkg::*;

    localparam int DW        = 32;
    localparam int ROWS      = 16;
    localparam int CB        = 2;
    localparam int DEPTH     = 4;
    localparam int IB        = 4;
    localparam int CTR_MAXV  = (1 << CB) - 1;
    localparam int CTR_WEAKV = 1 << (CB - 1);

    logic clk;
    logic rst;
    int   checksTotal;
    int   checksPassed;

    btb_ras_predictor_if #(.DATA_WIDTH(DW)) bus ();

    btb_ras_predictor #(
        .DATA_WIDTH   (DW),
        .BTB_ROWS     (ROWS),
        .COUNTER_BITS (CB),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: one record per BTB row plus a bounded list of return addresses.
    bit          mValid  [ROWS];
    logic [31:0] mTag    [ROWS];
    logic [31:0] mTarget [ROWS];
    int          mCtr    [ROWS];
    logic [1:0]  mKind   [ROWS];
    logic [31:0] rasQ    [$];

    function automatic int rowOf(input logic [31:0] pc);
        return int'((pc >> 2) % ROWS);
    endfunction

    function automatic logic [31:0] tagOf(input logic [31:0] pc);
        return pc >> (IB + 2);
    endfunction

    function automatic bit modelHit(input logic [31:0] pc);
        return mValid[rowOf(pc)] && (mTag[rowOf(pc)] == tagOf(pc));
    endfunction

    function automatic void modelPredict(input logic [31:0] pc, output bit hit,
                                         output bit taken, output logic [31:0] tgt);
        int r;
        logic [31:0] pc4;
        r   = rowOf(pc);
        pc4 = pc + 32'd4;
        hit = modelHit(pc);
        taken = 1'b0;
        tgt   = pc4;
        if (hit) begin
            case (mKind[r])
                2'b00: begin
                    taken = (mCtr[r] >= CTR_WEAKV);
                    tgt   = taken ? mTarget[r] : pc4;
                end
                2'b11: begin
                    taken = 1'b1;
                    tgt   = (rasQ.size() > 0) ? rasQ[rasQ.size()-1] : mTarget[r];
                end
                default: begin
                    taken = 1'b1;
                    tgt   = mTarget[r];
                end
            endcase
        end
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < ROWS; i++) begin
            mValid[i]  = 1'b0;
            mTag[i]    = '0;
            mTarget[i] = '0;
            mCtr[i]    = CTR_WEAKV;
            mKind[i]   = 2'b00;
        end
        rasQ.delete();
    endfunction

    function automatic void modelStep();
        bit h, t;
        logic [31:0] tg;
        int r;
        modelPredict(bus.pc_f, h, t, tg);
        r = rowOf(bus.pc_f);
        if (bus.flush_e) begin
            rasQ.delete();
        end else if (bus.fetch_fire_f && h) begin
            if (mKind[r] == 2'b10) begin
                rasQ.push_back(bus.pc_f + 32'd4);
                if (rasQ.size() > DEPTH) void'(rasQ.pop_front());
            end else if (mKind[r] == 2'b11 && rasQ.size() > 0) begin
                void'(rasQ.pop_back());
            end
        end
        if (bus.upd_valid_e) begin
            r = rowOf(bus.upd_pc_e);
            if (modelHit(bus.upd_pc_e)) begin
                if (bus.upd_kind_e == 2'b00) begin
                    if (bus.upd_taken_e) mCtr[r] = (mCtr[r] < CTR_MAXV) ? mCtr[r] + 1 : CTR_MAXV;
                    else                 mCtr[r] = (mCtr[r] > 0) ? mCtr[r] - 1 : 0;
                end
                if (bus.upd_taken_e) mTarget[r] = bus.upd_target_e;
                mKind[r] = bus.upd_kind_e;
            end else if (bus.upd_taken_e || bus.upd_kind_e != 2'b00) begin
                mValid[r]  = 1'b1;
                mTag[r]    = tagOf(bus.upd_pc_e);
                mTarget[r] = bus.upd_target_e;
                mCtr[r]    = CTR_WEAKV;
                mKind[r]   = bus.upd_kind_e;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input bit eHit, input bit eTaken,
                               input logic [31:0] eTarget);
        checksTotal++;
        if (bus.pred_hit_f !== eHit || bus.pred_taken_f !== eTaken ||
            bus.pred_target_f !== eTarget) begin
            $display("[TB] FAIL %s: got hit=%b taken=%b target=%h, expected hit=%b taken=%b target=%h",
                     name, bus.pred_hit_f, bus.pred_taken_f, bus.pred_target_f,
                     eHit, eTaken, eTarget);
        end else begin
            checksPassed++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input bit fire, input bit uv,
                                 input logic [31:0] upc, input logic [31:0] utgt,
                                 input bit utaken, input logic [1:0] ukind, input bit flush);
        bus.pc_f         = pc;
        bus.fetch_fire_f = fire;
        bus.upd_valid_e  = uv;
        bus.upd_pc_e     = upc;
        bus.upd_target_e = utgt;
        bus.upd_taken_e  = utaken;
        bus.upd_kind_e   = ukind;
        bus.flush_e      = flush;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic updateCycle(input logic [31:0] pc, input logic [31:0] tgt,
                               input bit taken, input logic [1:0] kind);
        applyStimulus(32'h0, 1'b0, 1'b1, pc, tgt, taken, kind, 1'b0);
        tick();
    endtask

    task automatic lookupCycle(input string name, input logic [31:0] pc, input bit fire,
                               input bit eHit, input bit eTaken, input logic [31:0] eTarget);
        applyStimulus(pc, fire, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        #2;
        checkOutput(name, eHit, eTaken, eTarget);
        tick();
    endtask

    function automatic logic [31:0] randPc();
        logic [31:0] pc;
        if ($urandom_range(0, 31) == 0) begin
            pc = 32'hFFFF_FFFC;
        end else begin
            pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
        end
        return pc;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) modelReset();
        else      modelStep();
    end

    // Every cycle out of reset the lookup outputs must match the model.
    always @(negedge clk) begin
        bit h, t;
        logic [31:0] tg;
        if (rst === 1'b1) begin
            modelPredict(bus.pc_f, h, t, tg);
            checkOutput("model_lookup", h, t, tg);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checksTotal  = 0;
        checksPassed = 0;
        modelReset();
        rst = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        repeat (3) tick();
        rst = 1'b1;

        lookupCycle("reset_miss", 32'h100, 1'b1, 1'b0, 1'b0, 32'h104);

        updateCycle(32'h100, 32'h200, 1'b1, 2'b00);
        lookupCycle("cond_alloc", 32'h100, 1'b0, 1'b1, 1'b1, 32'h200);
        updateCycle(32'h100, 32'h200, 1'b0, 2'b00);
        updateCycle(32'h100, 32'h200, 1'b0, 2'b00);
        lookupCycle("cond_not_taken", 32'h100, 1'b0, 1'b1, 1'b0, 32'h104);
        repeat (4) updateCycle(32'h100, 32'h200, 1'b1, 2'b00);
        lookupCycle("cond_saturate", 32'h100, 1'b0, 1'b1, 1'b1, 32'h200);
        updateCycle(32'h100, 32'h200, 1'b0, 2'b00);
        lookupCycle("cond_no_wrap", 32'h100, 1'b0, 1'b1, 1'b1, 32'h200);

        updateCycle(32'h140, 32'h600, 1'b0, 2'b00);
        lookupCycle("nt_miss_no_alloc", 32'h140, 1'b0, 1'b0, 1'b0, 32'h144);
        lookupCycle("alias_tag_miss", 32'h500, 1'b0, 1'b0, 1'b0, 32'h504);
        lookupCycle("entry_survives", 32'h100, 1'b0, 1'b1, 1'b1, 32'h200);
        lookupCycle("pc_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);

        updateCycle(32'h300, 32'h800, 1'b1, 2'b10);
        updateCycle(32'h804, 32'h900, 1'b1, 2'b11);
        lookupCycle("call_hit", 32'h300, 1'b1, 1'b1, 1'b1, 32'h800);
        lookupCycle("ret_from_ras", 32'h804, 1'b1, 1'b1, 1'b1, 32'h304);
        lookupCycle("ret_fallback", 32'h804, 1'b0, 1'b1, 1'b1, 32'h900);

        updateCycle(32'h310, 32'h800, 1'b1, 2'b10);
        updateCycle(32'h320, 32'h800, 1'b1, 2'b10);
        updateCycle(32'h330, 32'h800, 1'b1, 2'b10);
        for (int i = 0; i < 4; i++) begin
            lookupCycle("call_chain", 32'h300 + 32'(i * 16), 1'b1, 1'b1, 1'b1, 32'h800);
        end
        updateCycle(32'h340, 32'h800, 1'b1, 2'b10);
        lookupCycle("call_overflow", 32'h340, 1'b1, 1'b1, 1'b1, 32'h800);
        lookupCycle("ret_depth1", 32'h804, 1'b1, 1'b1, 1'b1, 32'h344);
        lookupCycle("ret_depth2", 32'h804, 1'b1, 1'b1, 1'b1, 32'h334);
        lookupCycle("ret_depth3", 32'h804, 1'b1, 1'b1, 1'b1, 32'h324);
        lookupCycle("ret_depth4", 32'h804, 1'b1, 1'b1, 1'b1, 32'h314);
        lookupCycle("ret_after_drain", 32'h804, 1'b1, 1'b1, 1'b1, 32'h900);

        lookupCycle("call_before_flush", 32'h320, 1'b1, 1'b1, 1'b1, 32'h800);
        applyStimulus(32'h310, 1'b1, 1'b1, 32'h3C8, 32'hABC, 1'b1, 2'b01, 1'b1);
        #2;
        checkOutput("call_with_flush", 1'b1, 1'b1, 32'h800);
        tick();
        lookupCycle("ret_after_flush", 32'h804, 1'b1, 1'b1, 1'b1, 32'h900);
        lookupCycle("update_during_flush", 32'h3C8, 1'b0, 1'b1, 1'b1, 32'hABC);

        applyStimulus(32'h310, 1'b0, 1'b1, 32'h3D0, 32'h123, 1'b1, 2'b01, 1'b0);
        #2;
        checkOutput("pre_reset_hit", 1'b1, 1'b1, 32'h800);
        rst = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 1'b0, 32'h314);
        repeat (2) tick();
        rst = 1'b1;
        lookupCycle("after_reset", 32'h310, 1'b0, 1'b0, 1'b0, 32'h314);
        lookupCycle("reset_drops_update", 32'h3D0, 1'b0, 1'b0, 1'b0, 32'h3D4);

        for (int n = 0; n < 1500; n++) begin
            applyStimulus(randPc(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                          randPc(), $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 1) == 1),
                          2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
            tick();
        end

        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        tick();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/btb_ras_predictor.md
Name: btb_ras_predictor

Overview:
- Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer with N-bit saturating counters, plus a return address stack (RAS) for call/return pairs.
- Lookup is combinational on the fetch PC.
- Training comes from the execute stage one resolved branch per cycle.
- A mispredict flush from execute clears speculative RAS state.

Parameters:
- DATA_WIDTH, 32, PC/target width.
- BTB_ROWS, 16, BTB entries; power of two, ≥2; INDEX_BITS = log2(BTB_ROWS).
- COUNTER_BITS, 2, saturating counter width; ≥1.
- RAS_DEPTH, 4, RAS entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- pc_f  in  DATA_WIDTH  fetch PC.
- fetch_fire_f  in  1  fetch PC accepted this cycle (not stalled).
- pred_hit_f  out  1  valid BTB entry with matching tag.
- pred_taken_f  out  1  predict redirect.
- pred_target_f  out  DATA_WIDTH  next-PC prediction.
- upd_valid_e  in  1  resolved control-transfer instruction.
- upd_pc_e  in  DATA_WIDTH  its PC.
- upd_target_e  in  DATA_WIDTH  resolved target.
- upd_taken_e  in  1  actual outcome.
- upd_kind_e  in  2  00 COND, 01 JUMP, 10 CALL, 11 RET.
- flush_e  in  1  mispredict/redirect flush.

Behaviour:
- Index and tag:
  - index = pc[INDEX_BITS+1:2].
  - tag = pc[DATA_WIDTH-1:INDEX_BITS+2].
- Entry fields: valid, tag, target, counter[COUNTER_BITS], kind[2].
- Reset (rst=0, async):
  - All valid=0, every counter set to 2^(COUNTER_BITS-1) (weak taken).
  - RAS count=0, RAS top pointer=0.
  - Outputs therefore read pred_hit_f=0, pred_taken_f=0, pred_target_f=pc_f+4.
- Lookup is purely combinational (0-cycle latency):
  - On a miss: pred_hit_f=0, pred_taken_f=0, pred_target_f=pc_f+4.
  - Hit, COND: pred_taken_f = counter MSB; target = entry.target if taken, else pc_f+4.
  - Hit, JUMP or CALL: taken=1, target = entry.target.
  - Hit, RET with RAS count>0: taken=1, target = RAS top.
  - Hit, RET with RAS empty: taken=1, target = entry.target (fallback).
- RAS (speculative, advances only on fetch_fire_f=1 and hit):
  - CALL pushes pc_f+4.
    - When full, the push overwrites the oldest entry (circular), count saturates at RAS_DEPTH, and the pointer still advances.
  - RET pops when count>0; no pop when empty.
  - flush_e=1 sets count=0 at the next edge and overrides any same-cycle push or pop.
  - Pointer arithmetic wraps modulo RAS_DEPTH.
- Update (registered, visible to lookup from the cycle after upd_valid_e):
  - Hit on upd_pc_e:
    - COND: counter saturating +1 if taken, -1 if not taken; no wrap at all-ones or zero.
    - If taken, target <= upd_target_e.
    - kind <= upd_kind_e.
  - Miss and (upd_taken_e=1 or kind≠COND):
    - Allocate: valid=1, tag, target, kind written.
    - Counter <= 2^(COUNTER_BITS-1) (weak taken); this overwrites any existing entry at that index.
  - Miss and a not-taken COND: no allocation, no state change.
  - For JUMP/CALL/RET the counter is written but ignored by lookup.
- Simultaneous events:
  - Lookup and update hitting the same index in one cycle: lookup returns pre-update contents; no bypass.
  - flush_e does not suppress a same-cycle update.
  - Reset asserted mid-operation discards any pending update and RAS activity immediately.
- Widths: pc+4 is computed modulo 2^DATA_WIDTH.
- No X on outputs at any time after reset.

Decomposition:
- Shared package bp_pkg:
  - Branch-kind enum (COND/JUMP/CALL/RET, 2 bits).
  - Counter helper functions: saturating increment/decrement parametrised by width via localparam in the module.
- Sub-module ras_stack (params DATA_WIDTH, RAS_DEPTH):
  - Ports: push, pop, push_data, flush, top, empty, full.
  - Contains the circular buffer and count logic.
- The BTB array and counter update stay in btb_ras_predictor.

Test Plan:
- After reset, pc_f=0x100 -> hit=0, taken=0, target=0x104; each update below is followed by a lookup one cycle later.
- Update COND pc=0x100, target=0x200, taken; then lookup 0x100 -> hit=1, taken=1, target=0x200. Two not-taken updates -> taken=0, target=0x104. Four taken updates -> counter saturates at 3 (no wrap to 0).
- Not-taken COND miss at pc=0x140 -> no allocation. Lookup 0x140 -> hit=0. Aliasing pc=0x500 (same index as 0x100, BTB_ROWS=16) after 0x100 is allocated -> tag mismatch -> hit=0.
- Allocate CALL at 0x300 (target 0x800) and RET at 0x804. Fetch-fire 0x300 -> target 0x800, RAS top=0x304. Fetch-fire 0x804 -> taken=1, target=0x304, RAS empty afterwards.
- Five fetch-fired CALL hits with RAS_DEPTH=4 (call PCs 0x300, 0x310, 0x320, 0x330, 0x340) -> count stays 4. Successive RETs return 0x344, 0x334, 0x324, 0x314. A fifth RET falls back to entry.target.
- flush_e asserted in the same cycle as a fetch-fired CALL hit -> RAS empty next cycle, and the next RET uses entry.target. Asserting rst mid-stream -> all hits=0 immediately.
